// File: rtl/lab1_imul_arb_pkg.sv
// lab1_imul_arb_pkg: shared FSM state and port-index types for the multiplier arbiter
package lab1_imul_arb_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
    typedef logic port_t;
endpackage

// File: rtl/lab1_imul_rr_arb2.sv
// lab1_imul_rr_arb2: two-input round-robin grant
//   val   - request valids, bit N for port N
//   prio  - port that wins when both are valid
//   grant - one-hot grant (all zero when nothing is valid)
module lab1_imul_rr_arb2
    import lab1_imul_arb_pkg::*;
(
    input  logic [1:0] val,
    input  port_t      prio,
    output logic [1:0] grant
);
    always_comb grant = (&val) ? (prio ? 2'b10 : 2'b01) : val;
endmodule

// File: rtl/lab1_imul_mul_arbiter.sv
// lab1_imul_mul_arbiter: shares one iterative multiplier between two requester ports
//   req0_*/req1_*   - val/rdy request ports, msg = {operand A, operand B}
//   resp0_*/resp1_* - val/rdy response ports carrying the 32-bit product
//   mul_req_*       - request port of the shared multiplier
//   mul_resp_*      - response port of the shared multiplier
//   done_cnt0/1     - per-port completed-transaction counters (wrap around)
module lab1_imul_mul_arbiter
    import lab1_imul_arb_pkg::*;
#(
    parameter int p_cnt_nbits = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req0_val,
    output logic                   req0_rdy,
    input  logic [63:0]            req0_msg,
    input  logic                   req1_val,
    output logic                   req1_rdy,
    input  logic [63:0]            req1_msg,
    output logic                   resp0_val,
    input  logic                   resp0_rdy,
    output logic [31:0]            resp0_msg,
    output logic                   resp1_val,
    input  logic                   resp1_rdy,
    output logic [31:0]            resp1_msg,
    output logic                   mul_req_val,
    input  logic                   mul_req_rdy,
    output logic [63:0]            mul_req_msg,
    input  logic                   mul_resp_val,
    output logic                   mul_resp_rdy,
    input  logic [31:0]            mul_resp_msg,
    output logic [p_cnt_nbits-1:0] done_cnt0,
    output logic [p_cnt_nbits-1:0] done_cnt1
);
    state_t                 state_q, state_d;
    port_t                  prio_q, prio_d;
    port_t                  owner_q, owner_d;
    logic [63:0]            buf_q, buf_d;
    logic [p_cnt_nbits-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;
    logic [1:0]             grant;
    logic                   owner_rdy;

    lab1_imul_rr_arb2 u_arb (
        .val   ({req1_val, req0_val}),
        .prio  (prio_q),
        .grant (grant)
    );

    // The response payload is a straight pass-through; only the valids are steered.
    assign resp0_msg   = mul_resp_msg;
    assign resp1_msg   = mul_resp_msg;
    assign mul_req_msg = buf_q;
    assign done_cnt0   = cnt0_q;
    assign done_cnt1   = cnt1_q;
    assign owner_rdy   = owner_q ? resp1_rdy : resp0_rdy;

    always_comb begin
        state_d      = state_q;
        prio_d       = prio_q;
        owner_d      = owner_q;
        buf_d        = buf_q;
        cnt0_d       = cnt0_q;
        cnt1_d       = cnt1_q;
        req0_rdy     = 1'b0;
        req1_rdy     = 1'b0;
        resp0_val    = 1'b0;
        resp1_val    = 1'b0;
        mul_req_val  = 1'b0;
        mul_resp_rdy = 1'b0;
        unique case (state_q)
            IDLE: begin
                req0_rdy = grant[0];
                req1_rdy = grant[1];
                if (|grant) begin
                    buf_d   = grant[1] ? req1_msg : req0_msg;
                    owner_d = grant[1];
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                mul_req_val = 1'b1;
                state_d     = mul_req_rdy ? WAIT : ISSUE;
            end
            WAIT: begin
                resp0_val    = !owner_q && mul_resp_val;
                resp1_val    = owner_q && mul_resp_val;
                mul_resp_rdy = owner_rdy;
                if (mul_resp_val && owner_rdy) begin
                    state_d = IDLE;
                    prio_d  = ~owner_q;
                    cnt0_d  = owner_q ? cnt0_q : cnt0_q + p_cnt_nbits'(1);
                    cnt1_d  = owner_q ? cnt1_q + p_cnt_nbits'(1) : cnt1_q;
                end
            end
            default: state_d = IDLE;
        endcase
        // State may still read ISSUE/WAIT during the reset cycle, so silence handshakes.
        if (reset) begin
            req0_rdy     = 1'b0;
            req1_rdy     = 1'b0;
            resp0_val    = 1'b0;
            resp1_val    = 1'b0;
            mul_req_val  = 1'b0;
            mul_resp_rdy = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            prio_q  <= 1'b0;
            owner_q <= 1'b0;
            buf_q   <= '0;
            cnt0_q  <= '0;
            cnt1_q  <= '0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            owner_q <= owner_d;
            buf_q   <= buf_d;
            cnt0_q  <= cnt0_d;
            cnt1_q  <= cnt1_d;
        end
    end
endmodule

// File: tb/tb_lab1_imul_mul_arbiter.sv
// tb_lab1_imul_mul_arbiter: randomized self-checking bench with a transaction-level arbiter model
module tb_lab1_imul_mul_arbiter;
    import lab1_imul_arb_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req0_val, req0_rdy, req1_val, req1_rdy;
    logic [63:0] req0_msg, req1_msg;
    logic        resp0_val, resp0_rdy, resp1_val, resp1_rdy;
    logic [31:0] resp0_msg, resp1_msg;
    logic        mul_req_val, mul_req_rdy, mul_resp_val, mul_resp_rdy;
    logic [63:0] mul_req_msg;
    logic [31:0] mul_resp_msg;
    logic [15:0] done_cnt0, done_cnt1;

    always #5 clk = ~clk;

    lab1_imul_mul_arbiter #(.p_cnt_nbits(16)) dut (
        .clk(clk), .reset(reset),
        .req0_val(req0_val), .req0_rdy(req0_rdy), .req0_msg(req0_msg),
        .req1_val(req1_val), .req1_rdy(req1_rdy), .req1_msg(req1_msg),
        .resp0_val(resp0_val), .resp0_rdy(resp0_rdy), .resp0_msg(resp0_msg),
        .resp1_val(resp1_val), .resp1_rdy(resp1_rdy), .resp1_msg(resp1_msg),
        .mul_req_val(mul_req_val), .mul_req_rdy(mul_req_rdy), .mul_req_msg(mul_req_msg),
        .mul_resp_val(mul_resp_val), .mul_resp_rdy(mul_resp_rdy), .mul_resp_msg(mul_resp_msg),
        .done_cnt0(done_cnt0), .done_cnt1(done_cnt1)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        int          port;
        logic [31:0] msg;
        int          acc;
        int          fire;
    } rec_t;

    rec_t        log_q[$];
    logic [63:0] q0[$];
    logic [63:0] q1[$];
    bit          hold0 = 1'b0;
    bit          hold1 = 1'b0;

    // Requesters: keep valid high from the head of each queue until it is accepted.
    initial begin
        bit f;
        req0_val = 1'b0;
        req0_msg = '0;
        forever begin
            @(negedge clk);
            f = req0_val && req0_rdy;
            @(posedge clk);
            #1;
            if (f) void'(q0.pop_front());
            req0_val = q0.size() > 0;
            req0_msg = req0_val ? q0[0] : 64'h0;
        end
    end

    initial begin
        bit f;
        req1_val = 1'b0;
        req1_msg = '0;
        forever begin
            @(negedge clk);
            f = req1_val && req1_rdy;
            @(posedge clk);
            #1;
            if (f) void'(q1.pop_front());
            req1_val = q1.size() > 0;
            req1_msg = req1_val ? q1[0] : 64'h0;
        end
    end

    // Response sinks: random back-pressure unless held low.
    initial begin
        resp0_rdy = 1'b0;
        resp1_rdy = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            resp0_rdy = !hold0 && ($urandom_range(0, 2) != 0);
            resp1_rdy = !hold1 && ($urandom_range(0, 2) != 0);
        end
    end

    // Shared multiplier: one outstanding op, random latency, holds its response until taken.
    initial begin
        bit          rq, rs, rst_s, have;
        logic [31:0] p, prod;
        int unsigned dly;
        have = 1'b0;
        prod = '0;
        dly = 0;
        mul_req_rdy = 1'b0;
        mul_resp_val = 1'b0;
        mul_resp_msg = '0;
        forever begin
            @(negedge clk);
            rq = mul_req_val && mul_req_rdy;
            rs = mul_resp_val && mul_resp_rdy;
            rst_s = reset;
            p = mul_req_msg[63:32] * mul_req_msg[31:0];
            @(posedge clk);
            #1;
            if (rst_s) begin
                have = 1'b0;
                mul_resp_val = 1'b0;
            end else begin
                if (rs) begin
                    have = 1'b0;
                    mul_resp_val = 1'b0;
                end
                if (rq) begin
                    have = 1'b1;
                    prod = p;
                    dly = $urandom_range(0, 3);
                end
                if (have && !mul_resp_val) begin
                    if (dly == 0) begin
                        mul_resp_val = 1'b1;
                        mul_resp_msg = prod;
                    end else dly--;
                end
            end
            if (!mul_resp_val) mul_resp_msg = $urandom;
            mul_req_rdy = !have && ($urandom_range(0, 2) != 0);
        end
    end

    // Reference model: one transaction in flight, round-robin pick when both wait,
    // pointer moves to the other port after each completion.
    initial begin
        bit          busy, issued, own, ptr, w0, w1, orr;
        logic [15:0] c0, c1;
        logic [63:0] em;
        logic [31:0] ep;
        int          acc, cyc;
        busy = 0; issued = 0; own = 0; ptr = 0;
        c0 = '0; c1 = '0; em = '0; ep = '0; acc = 0; cyc = 0;
        forever begin
            @(negedge clk);
            cyc++;
            chk("done_cnt0", 64'(done_cnt0), 64'(c0));
            chk("done_cnt1", 64'(done_cnt1), 64'(c1));
            if (reset) begin
                chk("reset_handshakes", 64'({req0_rdy, req1_rdy, resp0_val, resp1_val, mul_req_val, mul_resp_rdy}), 64'(0));
                busy = 0; issued = 0; own = 0; ptr = 0; c0 = '0; c1 = '0;
            end else if (!busy) begin
                w0 = req0_val && (!req1_val || !ptr);
                w1 = req1_val && (!req0_val || ptr);
                chk("idle_req_rdy", 64'({req0_rdy, req1_rdy}), 64'({w0, w1}));
                chk("idle_quiet", 64'({resp0_val, resp1_val, mul_req_val, mul_resp_rdy}), 64'(0));
                if (w0 || w1) begin
                    busy = 1; issued = 0; own = w1;
                    em = w1 ? req1_msg : req0_msg;
                    ep = em[63:32] * em[31:0];
                    acc = cyc;
                end
            end else if (!issued) begin
                chk("issue_ctl", 64'({mul_req_val, req0_rdy, req1_rdy, resp0_val, resp1_val, mul_resp_rdy}), 64'(6'b100000));
                chk("issue_msg", mul_req_msg, em);
                if (mul_req_rdy) issued = 1;
            end else begin
                orr = own ? resp1_rdy : resp0_rdy;
                chk("wait_ctl", 64'({req0_rdy, req1_rdy, mul_req_val, resp0_val, resp1_val, mul_resp_rdy}),
                    64'({3'b000, !own && mul_resp_val, own && mul_resp_val, orr}));
                if (mul_resp_val) chk("wait_msg", 64'(own ? resp1_msg : resp0_msg), 64'(ep));
                if (mul_resp_val && orr) begin
                    log_q.push_back('{int'(own), own ? resp1_msg : resp0_msg, acc, cyc});
                    if (own) c1 = c1 + 16'd1;
                    else c0 = c0 + 16'd1;
                    ptr = !own;
                    busy = 0;
                end
            end
        end
    end

    task automatic wait_log(input int n);
        int k = 0;
        while (log_q.size() < n && k < 20000) begin
            @(negedge clk);
            #1;
            k++;
        end
        chk("wait_log", 64'(log_q.size() >= n), 64'(1));
    endtask

    task automatic wait_resp(input bit port);
        int k = 0;
        while (!(port ? resp1_val : resp0_val) && k < 200) begin
            @(negedge clk);
            #1;
            k++;
        end
        chk("wait_resp_val", 64'(port ? resp1_val : resp0_val), 64'(1));
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    function automatic logic [31:0] rand_op();
        int unsigned s = $urandom_range(0, 7);
        return s == 0 ? 32'h0 : s == 1 ? 32'hFFFF_FFFF : 32'($urandom);
    endfunction

    initial begin
        int n0, n1, m0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        #1;
        chk("rst_state", 64'(dut.state_q), 64'(IDLE));
        chk("rst_cnt", 64'({done_cnt0, done_cnt1}), 64'(0));

        // 3 x 4 on port 0 alone
        @(negedge clk);
        #2;
        q0.push_back({32'd3, 32'd4});
        wait_log(1);
        chk("single_port", 64'(log_q[0].port), 64'(0));
        chk("single_msg", 64'(log_q[0].msg), 64'(32'h0000_000C));
        @(negedge clk);
        #1;
        chk("single_cnt0", 64'(done_cnt0), 64'(1));

        // both ports in the same cycle out of reset: port 0 first
        pulse_reset();
        log_q.delete();
        @(negedge clk);
        #2;
        q0.push_back({32'd5, 32'd6});
        q1.push_back({32'd7, 32'd8});
        wait_log(2);
        chk("both_first_port", 64'(log_q[0].port), 64'(0));
        chk("both_first_msg", 64'(log_q[0].msg), 64'(32'h1E));
        chk("both_second_port", 64'(log_q[1].port), 64'(1));
        chk("both_second_msg", 64'(log_q[1].msg), 64'(32'h38));

        // back-to-back on port 1
        log_q.delete();
        @(negedge clk);
        #2;
        q1.push_back({32'd2, 32'd2});
        q1.push_back({32'd9, 32'd9});
        q1.push_back({32'hFFFF_FFFF, 32'd2});
        wait_log(3);
        chk("b2b_msg0", 64'(log_q[0].msg), 64'(32'd4));
        chk("b2b_msg1", 64'(log_q[1].msg), 64'(32'd81));
        chk("b2b_msg2", 64'(log_q[2].msg), 64'(32'hFFFF_FFFE));
        chk("b2b_gap1", 64'(log_q[1].acc - log_q[0].fire <= 2), 64'(1));
        chk("b2b_gap2", 64'(log_q[2].acc - log_q[1].fire <= 2), 64'(1));

        // response back-pressure on port 1
        log_q.delete();
        @(negedge clk);
        #2;
        hold1 = 1'b1;
        q1.push_back({32'd7, 32'd8});
        wait_resp(1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            chk("stall_mul_resp_rdy", 64'(mul_resp_rdy), 64'(0));
            chk("stall_resp1_msg", 64'(resp1_msg), 64'(32'h38));
            chk("stall_state", 64'(dut.state_q), 64'(WAIT));
        end
        hold1 = 1'b0;
        wait_log(1);
        chk("stall_final_msg", 64'(log_q[0].msg), 64'(32'h38));

        // reset while waiting with done_cnt0 = 3
        pulse_reset();
        log_q.delete();
        @(negedge clk);
        #2;
        q0.push_back({32'd1, 32'd1});
        q0.push_back({32'd2, 32'd2});
        q0.push_back({32'd3, 32'd3});
        wait_log(3);
        @(negedge clk);
        #2;
        hold0 = 1'b1;
        q0.push_back({32'd4, 32'd4});
        q0.push_back({32'd5, 32'd5});
        wait_resp(1'b0);
        chk("pre_rst_cnt0", 64'(done_cnt0), 64'(3));
        chk("pre_rst_state", 64'(dut.state_q), 64'(WAIT));
        pulse_reset();
        @(negedge clk);
        #1;
        chk("post_rst_state", 64'(dut.state_q), 64'(IDLE));
        chk("post_rst_cnt0", 64'(done_cnt0), 64'(0));
        chk("post_rst_resp_val", 64'({resp0_val, resp1_val}), 64'(0));
        chk("post_rst_req0", 64'({req0_val, req0_rdy}), 64'(2'b11));
        hold0 = 1'b0;
        wait_log(4);
        chk("post_rst_msg", 64'(log_q[3].msg), 64'(32'd25));

        // random traffic on both ports
        log_q.delete();
        n0 = 0;
        n1 = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            #2;
            if ($urandom_range(0, 2) == 0) begin
                q0.push_back({rand_op(), rand_op()});
                n0++;
            end
            if ($urandom_range(0, 2) == 0) begin
                q1.push_back({rand_op(), rand_op()});
                n1++;
            end
        end
        wait_log(n0 + n1);
        m0 = 0;
        foreach (log_q[i]) if (log_q[i].port == 0) m0++;
        chk("rand_port0_count", 64'(m0), 64'(n0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
